wb_host_arbiter: RTL and testbench

Shares one Wishbone pipelined master port between `NrHosts` Ibex-style hosts (core data port, debug host) using round-robin arbitration. Each granted request is converted into exactly one Wishbone transaction. Only one transaction is outstanding at a time, and a timeout aborts hung slaves. The block sits between the host request ports and the Wishbone crossbar or master port. It replaces per-host `cyc`/`stb` bookkeeping with a single sequenced owner.

---
 rtl/wb_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/wb_host_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_host_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone host arbiter.
//   wb_arb_state_e : sequencing states of the single-owner transaction FSM
//   wb_arb_req_t   : one latched host request (addr, we, be, wdata) at the
//                    default 32-bit address / 32-bit data widths
//   idx_width()    : width of a host index, never less than one bit
package wb_arb_pkg;

  localparam int unsigned ArbAddrWidth = 32;
  localparam int unsigned ArbDataWidth = 32;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbReq  = 2'd1,
    ArbWait = 2'd2,
    ArbResp = 2'd3
  } wb_arb_state_e;

  typedef struct packed {
    logic [ArbAddrWidth-1:0]   addr;
    logic                      we;
    logic [ArbDataWidth/8-1:0] be;
    logic [ArbDataWidth-1:0]   wdata;
  } wb_arb_req_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently; the search starts just above it
//   gnt        : one-hot grant (zero when nothing requests)
//   gnt_idx    : index of the granted requester (0 when nothing requests)
module rr_arbiter import wb_arb_pkg::*; #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last_grant,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [N-1:0] req_above;
  logic         any_above;

  // Requesters above the pointer have priority; if none, wrap around and take
  // the lowest requesting index overall.
  always_comb begin
    // NOTE: every signal gets a default before any conditional update, so no
    // path leaves a combinational output unassigned and no latch is inferred.
    req_above = '0;
    gnt_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_above[i] = req[i] && (IdxW'(i) > last_grant);
    end
    any_above = |req_above;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (any_above ? req_above[i] : req[i]) gnt_idx = IdxW'(i);
    end
    gnt = (|req) ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/wb_host_arbiter.sv
// Shares one Wishbone pipelined master port between NrHosts Ibex-style hosts.
// One transaction is outstanding at a time; a timeout aborts hung slaves.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   host_req_i/gnt_o  : request / combinational one-hot grant (only in idle)
//   host_addr/we/be/wdata_i : request fields, latched on grant
//   host_rvalid/rdata/err_o : registered one-cycle response to the owner only
//   wb_cyc/stb/we/addr/data/sel_o : registered Wishbone master outputs
//   wb_stall/ack/err/data_i       : Wishbone slave responses
module wb_host_arbiter import wb_arb_pkg::*; #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [AddressWidth-1:0]   wb_addr_o,
  output logic [DataWidth-1:0]      wb_data_o,
  output logic [DataWidth/8-1:0]    wb_sel_o,
  input  logic                      wb_stall_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic [DataWidth-1:0]      wb_data_i
);

  localparam int unsigned IdxW = idx_width(NrHosts);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  typedef struct packed {
    logic [AddressWidth-1:0]  addr;
    logic                     we;
    logic [DataWidth/8-1:0]   be;
    logic [DataWidth-1:0]     wdata;
  } req_t;

  wb_arb_state_e          state_q, state_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  req_t                   req_q, req_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic [NrHosts-1:0]     rvalid_q, rvalid_d;
  logic [NrHosts-1:0]     err_q, err_d;
  logic [DataWidth-1:0]   rdata_q [NrHosts];
  logic [DataWidth-1:0]   rdata_d [NrHosts];

  logic [NrHosts-1:0]     arb_gnt;
  logic [IdxW-1:0]        arb_idx;
  logic                   timeout_hit;
  logic                   resp_err;
  logic [DataWidth-1:0]   resp_data;

  rr_arbiter #(.N(NrHosts)) u_rr (
    .req        (host_req_i),
    .last_grant (last_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  assign host_gnt_o  = (state_q == ArbIdle) ? arb_gnt : '0;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    resp_err  = 1'b0;
    resp_data = '0;

    case (state_q)
      ArbIdle: begin
        if (|host_req_i) begin
          state_d     = ArbReq;
          owner_d     = arb_idx;
          last_d      = arb_idx;
          req_d.addr  = host_addr_i[arb_idx];
          req_d.we    = host_we_i[arb_idx];
          req_d.be    = host_be_i[arb_idx];
          req_d.wdata = host_wdata_i[arb_idx];
          cnt_d       = '0;
        end
      end
      ArbReq, ArbWait: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (wb_ack_i || wb_err_i || timeout_hit) begin
          state_d   = ArbResp;
          // Error if the slave says so, or if the timeout fired without an ack;
          // an ack landing on the timeout cycle still counts as success.
          resp_err  = wb_err_i || !wb_ack_i;
          resp_data = (wb_ack_i && !wb_err_i && !req_q.we) ? wb_data_i : '0;
        end else if (state_q == ArbReq && !wb_stall_i) begin
          state_d = ArbWait;
        end
      end
      ArbResp: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    cyc_d = (state_d == ArbReq) || (state_d == ArbWait);
    stb_d = (state_d == ArbReq);
    for (int i = 0; i < int'(NrHosts); i++) begin
      rvalid_d[i] = 1'b0;
      err_d[i]    = 1'b0;
      rdata_d[i]  = '0;
      if (state_d == ArbResp && owner_q == IdxW'(i)) begin
        rvalid_d[i] = 1'b1;
        err_d[i]    = resp_err;
        rdata_d[i]  = resp_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ArbIdle;
      last_q   <= IdxW'(NrHosts - 1);
      owner_q  <= '0;
      req_q    <= '0;
      cnt_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      rvalid_q <= '0;
      err_q    <= '0;
      // NOTE: rdata_q is output state rather than storage, so it is reset
      // with everything else to keep the outputs at zero.
      rdata_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = req_q.we;
  assign wb_addr_o     = req_q.addr;
  assign wb_data_o     = req_q.wdata;
  assign wb_sel_o      = req_q.be;
  assign host_rvalid_o = rvalid_q;
  assign host_err_o    = err_q;
  assign host_rdata_o  = rdata_q;

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Randomized self-checking bench for wb_host_arbiter (2 hosts, timeout of 8).
// The reference works per transaction: who wins by round robin, how many
// cycles the bus stays busy, and what response the owner must see.
module tb_wb_host_arbiter;
  import wb_arb_pkg::*;

  localparam int NH = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  host_req = '0;
  logic [1:0]  host_gnt;
  logic [31:0] host_addr  [NH];
  logic [1:0]  host_we = '0;
  logic [3:0]  host_be    [NH];
  logic [31:0] host_wdata [NH];
  logic [1:0]  host_rvalid;
  logic [31:0] host_rdata [NH];
  logic [1:0]  host_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  int model_last = NH - 1;

  wb_host_arbiter #(
    .NrHosts(NH), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_addr_i(host_addr), .host_we_i(host_we), .host_be_i(host_be),
    .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_addr_o(wb_addr), .wb_data_o(wb_wdata), .wb_sel_o(wb_sel),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_data_i(wb_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round robin: first requester found walking upward from last+1, wrapping.
  function automatic int rr_pick(input logic [1:0] m, input int last);
    for (int off = 1; off <= NH; off++) begin
      int c;
      c = (last + off) % NH;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic scramble_hosts();
    for (int i = 0; i < NH; i++) begin
      host_addr[i]  = $urandom;
      host_we[i]    = 1'($urandom);
      host_be[i]    = 4'($urandom);
      host_wdata[i] = $urandom;
    end
  endtask

  // Runs one transaction starting at a negedge with the DUT idle.
  // stall_n : leading bus cycles with wb_stall_i high
  // resp_k  : bus cycle (1 = first stb cycle) carrying the response; beyond
  //           TO+1 means the slave never answers
  // kind    : 0 ack, 1 err, 2 ack and err together
  task automatic run_tx(input string name, input logic [1:0] mask, input int stall_n,
                        input int resp_k, input int kind, input logic [31:0] sdata);
    int          w, done_k;
    logic [1:0]  exp_onehot;
    logic        exp_err, has_resp;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;

    host_req = mask;
    #1;
    w = rr_pick(mask, model_last);
    exp_onehot = 2'b01 << w;
    check({name, ".gnt"}, 64'(host_gnt), 64'(exp_onehot));
    model_last = w;
    exp_addr  = host_addr[w];
    exp_we    = host_we[w];
    exp_be    = host_be[w];
    exp_wdata = host_wdata[w];
    has_resp  = (resp_k <= TO + 1);
    done_k    = has_resp ? resp_k : TO + 1;
    exp_err   = has_resp ? (kind != 0) : 1'b1;
    exp_rdata = (has_resp && kind == 0 && !exp_we) ? sdata : 32'h0;
    @(posedge clk);

    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      scramble_hosts();
      wb_stall = (k <= stall_n);
      wb_ack   = (k == resp_k) && (kind != 1);
      wb_err   = (k == resp_k) && (kind != 0);
      wb_rdata = (k == resp_k) ? sdata : $urandom;
      #1;
      check({name, ".cyc"}, 64'(wb_cyc), 64'(1'b1));
      check({name, ".stb"}, 64'(wb_stb), 64'(k <= stall_n + 1));
      check({name, ".busy_gnt"}, 64'(host_gnt), 64'(2'b00));
      check({name, ".busy_rvalid"}, 64'(host_rvalid), 64'(2'b00));
      check({name, ".addr"}, 64'(wb_addr), 64'(exp_addr));
      check({name, ".we_sel_data"}, 64'({wb_we, wb_sel, wb_wdata}),
            64'({exp_we, exp_be, exp_wdata}));
      @(posedge clk);
    end

    @(negedge clk);
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = $urandom;
    #1;
    check({name, ".resp_cyc"}, 64'({wb_cyc, wb_stb}), 64'(2'b00));
    check({name, ".rvalid"}, 64'(host_rvalid), 64'(exp_onehot));
    check({name, ".err"}, 64'(host_err), 64'(exp_onehot & {2{exp_err}}));
    check({name, ".rdata_owner"}, 64'(host_rdata[w]), 64'(exp_rdata));
    check({name, ".rdata_other"}, 64'(host_rdata[1-w]), 64'(0));
    check({name, ".resp_gnt"}, 64'(host_gnt), 64'(2'b00));
    @(posedge clk);
    @(negedge clk);
    host_req = '0;
    #1;
    check({name, ".rvalid_pulse"}, 64'(host_rvalid), 64'(2'b00));
  endtask

  initial begin
    scramble_hosts();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst.wb", 64'({wb_cyc, wb_stb, wb_we, wb_sel}), 64'(0));
    check("rst.wb_addr_data", 64'({wb_addr, wb_wdata}), 64'(0));
    check("rst.host", 64'({host_rvalid, host_err, host_gnt}), 64'(0));
    check("rst.rdata", 64'({host_rdata[0], host_rdata[1]}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single read from host 0.
    host_addr[0] = 32'h8000_1000; host_we[0] = 1'b0; host_be[0] = 4'hF;
    run_tx("read", 2'b01, 0, 2, 0, 32'hDEAD_BEEF);

    // Write from host 1.
    host_addr[1] = 32'h0000_2000; host_we[1] = 1'b1; host_be[1] = 4'b0011;
    host_wdata[1] = 32'h1234_5678;
    run_tx("write", 2'b10, 0, 2, 0, 32'hCAFE_F00D);

    // Round robin with both hosts requesting.
    for (int i = 0; i < 4; i++) begin
      host_we = 2'b00;
      run_tx($sformatf("rr%0d", i), 2'b11, 0, 2, 0, $urandom);
    end

    // Stall three cycles, then ack and err together.
    host_we[0] = 1'b0;
    run_tx("stall_err", 2'b01, 3, 4, 2, 32'h5555_AAAA);

    // Timeout, then a following request is still served.
    run_tx("timeout", 2'b10, 0, 100, 0, 32'h0);
    host_we[0] = 1'b0;
    run_tx("after_to", 2'b01, 1, 3, 0, 32'h0BAD_CAFE);

    // Ack arriving exactly on the timeout cycle wins over the timeout.
    host_we[1] = 1'b0;
    run_tx("ack_at_to", 2'b10, 0, TO + 1, 0, 32'h7777_1234);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_tx($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)), $urandom_range(0, 3),
             $urandom_range(1, TO + 3), $urandom_range(0, 2), $urandom);
    end

    // Reset during ArbWait: bus drops at once, no response afterwards.
    host_req = 2'b01;
    @(posedge clk);
    @(negedge clk);
    host_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid.wait_state", 64'({wb_cyc, wb_stb}), 64'(2'b10));
    rst = 1'b1;
    #1;
    check("mid.rst_drop", 64'({wb_cyc, wb_stb}), 64'(2'b00));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("mid.no_rvalid", 64'({host_rvalid, wb_cyc}), 64'(0));
    end
    model_last = NH - 1;
    run_tx("post_rst", 2'b11, 0, 2, 0, $urandom);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
